add_sub_iter: RTL and testbench

//   Parametrised, multi-cycle 2's-complement adder/subtractor for the ALU datapath.

---
 rtl/add_sub_pkg.sv | 5 +
 rtl/add_sub_slice.sv | 15 +
 rtl/add_sub_iter.sv | 112 +++++++++++
 tb/tb_add_sub_iter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: op and FSM state encodings shared by the iterative adder/subtractor.
package add_sub_pkg;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_ADC = 2'd2, OP_SBC = 2'd3} op_e;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;
endpackage

// File: rtl/add_sub_slice.sv
// add_sub_slice: combinational CHUNK-bit adder exposing the carry into its top bit.
module add_sub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    // carry into the top bit recovered from its sum bit, valid for any CHUNK >= 1
    assign c_msb_in = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
endmodule

// File: rtl/add_sub_iter.sv
// add_sub_iter: multi-cycle add/sub, one CHUNK slice per clock, with C/V/Z/N flags.
module add_sub_iter
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $fatal(1, "add_sub_iter: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, out_sum_q, out_sum_d;
    logic             out_c_q, out_c_d, out_v_q, out_v_d, out_z_q, out_z_d, out_n_q, out_n_d;
    logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout, sl_cmsb, accept, calc, last, carry0;

    assign sl_a = a_q[k_q*CHUNK +: CHUNK];
    assign sl_b = b_q[k_q*CHUNK +: CHUNK];

    add_sub_slice #(.CHUNK(CHUNK)) u_slice (
        .a(sl_a), .b(sl_b), .cin(carry_q), .sum(sl_sum), .cout(sl_cout), .c_msb_in(sl_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            out_sum_q <= '0;
            out_c_q   <= 1'b0;
            out_v_q   <= 1'b0;
            out_z_q   <= 1'b0;
            out_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            out_sum_q <= out_sum_d;
            out_c_q   <= out_c_d;
            out_v_q   <= out_v_d;
            out_z_q   <= out_z_d;
            out_n_q   <= out_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_CALC;
            S_CALC:  if (k_q == KLAST) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign accept = in_valid && (state_q == S_IDLE);
    assign calc   = (state_q == S_CALC);
    assign last   = calc && (k_q == KLAST);
    assign carry0 = (in_op == OP_ADD) ? 1'b0 : (in_op == OP_SUB) ? 1'b1 : in_cin;

    always_comb begin
        a_d     = accept ? in_a : a_q;
        b_d     = accept ? (in_op[0] ? ~in_b : in_b) : b_q;
        k_d     = (accept || last) ? '0 : calc ? k_q + KW'(1) : k_q;
        carry_d = accept ? carry0 : calc ? sl_cout : carry_q;
        sum_d   = accept ? '0 : sum_q;
        if (calc) sum_d[k_q*CHUNK +: CHUNK] = sl_sum;
        // results are published only when the final slice completes
        out_sum_d = last ? sum_d : out_sum_q;
        out_c_d   = last ? sl_cout : out_c_q;
        out_v_d   = last ? (sl_cmsb ^ sl_cout) : out_v_q;
        out_z_d   = last ? (sum_d == '0) : out_z_q;
        out_n_d   = last ? sum_d[WIDTH-1] : out_n_q;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = out_sum_q;
    assign out_c     = out_c_q;
    assign out_v     = out_v_q;
    assign out_z     = out_z_q;
    assign out_n     = out_n_q;
endmodule

// File: tb/tb_add_sub_iter.sv
// tb_add_sub_iter: randomized scoreboard bench for add_sub_iter against an integer reference model.
module tb_add_sub_iter;
    import add_sub_pkg::*;
    localparam int W = 16;
    localparam int C = 4;
    localparam int NS = W / C;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, in_cin = 1'b0, hold = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [1:0]   in_op = '0;
    logic         in_ready, out_valid, out_c, out_v, out_z, out_n;
    logic [W-1:0] out_sum;

    add_sub_iter #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic c, v, z, n;
        int acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;
    logic seen = 1'b0;
    logic [W+3:0] snap;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    function automatic exp_t model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
        exp_t e;
        longint ua, ub, sa, sbv, ur, sr, k;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'(signed'(a));
        sbv = longint'(signed'(b));
        if (op == OP_ADD || op == OP_ADC) begin
            k = (op == OP_ADC) ? longint'(cin) : 0;
            ur = ua + ub + k;
            sr = sa + sbv + k;
            e.c = (ur >= (longint'(1) << W));
        end else begin
            k = (op == OP_SBC) ? longint'(!cin) : 0;
            ur = ua - ub - k;
            sr = sa - sbv - k;
            e.c = (ur >= 0);
        end
        e.s = ur[W-1:0];
        e.v = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
        e.z = (e.s == '0);
        e.n = e.s[W-1];
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("issue_timeout");
        else begin
            in_valid = 1'b1;
            in_op = op;
            in_a = a;
            in_b = b;
            in_cin = cin;
            @(posedge clk);
            #1;
            e = model(op, a, b, cin);
            e.acc = cyc;
            sb.push_back(e);
            in_valid = 1'b0;
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_op = 2'($urandom);
            in_cin = 1'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) seen = 1'b0;
        else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                snap = {out_sum, out_c, out_v, out_z, out_n};
                if (sb.size() == 0) fail_now("unexpected_output");
                else chk("latency", cyc - sb[0].acc, NS);
            end else chk("stable_in_done", 32'(snap), 32'({out_sum, out_c, out_v, out_z, out_n}));
            chk("in_ready_in_done", 32'(in_ready), 0);
            if (out_ready) begin
                seen = 1'b0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sum", 32'(out_sum), 32'(e.s));
                    chk("flag_c", 32'(out_c), 32'(e.c));
                    chk("flag_v", 32'(out_v), 32'(e.v));
                    chk("flag_z", 32'(out_z), 32'(e.z));
                    chk("flag_n", 32'(out_n), 32'(e.n));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] corner [4];
        corner[0] = '0;
        corner[1] = '1;
        corner[2] = 16'h8000;
        corner[3] = 16'h7FFF;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_flags", 32'({out_c, out_v, out_z, out_n}), 0);
        rst = 1'b0;

        issue(OP_ADD, 16'h00FF, 16'h0001, 1'b0);
        issue(OP_SUB, 16'h8000, 16'h0001, 1'b0);
        issue(OP_SUB, 16'h0005, 16'h0005, 1'b0);
        issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        issue(OP_ADC, 16'hFFFF, 16'h0000, 1'b1);
        issue(OP_SBC, 16'h0000, 16'h0000, 1'b0);
        drain();

        hold = 1'b1;
        @(posedge clk);
        issue(OP_SBC, 16'h1234, 16'h0FFF, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_a = W'($urandom);
            in_b = W'($urandom);
        end
        @(negedge clk);
        chk("held_out_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        hold = 1'b0;
        drain();

        issue(OP_ADD, 16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_sum", 32'(out_sum), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(OP_ADD, 16'h1234, 16'h1111, 1'b0);
        drain();

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            issue(2'($urandom), a, b, 1'($urandom));
        end
        drain();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
